// File: rtl/dmac_ch_sched.sv
`default_nettype none
// dmac_ch_sched: round-robin scheduler that multiplexes N_CH DMA channels onto one transfer engine.
// Captures start pulses, snapshots the winner's source/destination/length and runs the engine handshake.
module dmac_ch_sched #(
  parameter int N_CH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    start_i,
  input  logic [N_CH*32-1:0] src_addr_i,
  input  logic [N_CH*32-1:0] dst_addr_i,
  input  logic [N_CH*16-1:0] byte_len_i,
  output logic [N_CH-1:0]    done_o,
  output logic               eng_start_o,
  output logic [31:0]        eng_src_addr_o,
  output logic [31:0]        eng_dst_addr_o,
  output logic [15:0]        eng_byte_len_o,
  input  logic               eng_done_i,
  output logic               busy_o,
  output logic [2:0]         cur_ch_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] grant_mask;
  logic [N_CH-1:0] set_done;
  logic [2:0]      rr_ptr;
  logic [2:0]      win_ch;
  logic            win_found;
  logic [31:0]     win_src;
  logic [31:0]     win_dst;
  logic [15:0]     win_len;
  logic            grant;
  logic            complete;

  // A channel that is pending or in flight has done_o low, so its start pulses fall away here.
  assign accept = start_i & done_o;

  always_comb begin : arb
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_ch    = 3'd0;
    win_src   = 32'd0;
    win_dst   = 32'd0;
    win_len   = 16'd0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_ch    = 3'(idx);
        win_src   = src_addr_i[32*idx +: 32];
        win_dst   = dst_addr_i[32*idx +: 32];
        win_len   = byte_len_i[16*idx +: 16];
      end
    end
  end

  always_comb begin : fsm
    state_n  = state;
    grant    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && eng_done_i) begin
          grant = 1'b1;
          // Zero-length requests finish on the grant itself and never wake the engine.
          if (win_len != 16'd0) state_n = ISSUE;
        end
      end
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (!eng_done_i) state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (eng_done_i) begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin : masks
    grant_mask = '0;
    set_done   = '0;
    if (grant) grant_mask = N_CH'(1) << win_ch;
    if (grant && win_len == 16'd0) set_done = set_done | grant_mask;
    if (complete) set_done = set_done | (N_CH'(1) << cur_ch_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      done_o         <= '1;
      rr_ptr         <= 3'(N_CH - 1);
      eng_start_o    <= 1'b0;
      eng_src_addr_o <= 32'd0;
      eng_dst_addr_o <= 32'd0;
      eng_byte_len_o <= 16'd0;
      busy_o         <= 1'b0;
      cur_ch_o       <= 3'd0;
    end else begin
      pending     <= (pending | accept) & ~grant_mask;
      done_o      <= (done_o & ~accept) | set_done;
      eng_start_o <= (state_n == ISSUE);
      busy_o      <= (state_n != IDLE);
      if (grant) begin
        eng_src_addr_o <= win_src;
        eng_dst_addr_o <= win_dst;
        eng_byte_len_o <= win_len;
        cur_ch_o       <= win_ch;
        rr_ptr         <= win_ch;
      end
    end
  end

endmodule
`default_nettype wire
